// File: rtl/riscv_pkg.sv
// Shared core definitions: register width, 4-bit ALU opcodes and the
// arbiter state encoding.
package riscv_pkg;

    localparam int REG_WIDTH = 32;

    localparam logic [3:0] ALU_OR   = 4'b0000;
    localparam logic [3:0] ALU_AND  = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0011;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_XOR  = 4'b1001;
    localparam logic [3:0] ALU_SRL  = 4'b1010;
    localparam logic [3:0] ALU_SRA  = 4'b1011;
    localparam logic [3:0] ALU_SLTU = 4'b1101;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } alu_arb_state_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Purely combinational integer ALU; unknown opcodes produce zero and
// shifts use only the low five bits of operand B.
module alu_arbiter_alu
    import riscv_pkg::*;
(
    input  logic [3:0]           op,
    input  logic [REG_WIDTH-1:0] a,
    input  logic [REG_WIDTH-1:0] b,
    output logic [REG_WIDTH-1:0] result
);

    logic signed [REG_WIDTH-1:0] a_s;
    logic signed [REG_WIDTH-1:0] b_s;
    logic [4:0]                  shamt;

    assign a_s   = a;
    assign b_s   = b;
    assign shamt = b[4:0];

    always_comb begin
        result = '0;
        case (op)
            ALU_OR:   result = a | b;
            ALU_AND:  result = a & b;
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_SLT:  result = {{(REG_WIDTH-1){1'b0}}, (a_s < b_s)};
            ALU_SLL:  result = a << shamt;
            ALU_XOR:  result = a ^ b;
            ALU_SRL:  result = a >> shamt;
            ALU_SRA:  result = a_s >>> shamt;
            ALU_SLTU: result = {{(REG_WIDTH-1){1'b0}}, (a < b)};
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU among NUM_REQ requesters with a
// registered, held result. Define ALU_ARB_FIXED_PRIO_EN for fixed priority.
module alu_arbiter
    import riscv_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_REQ-1:0]                req_valid,
    output logic [NUM_REQ-1:0]                req_ready,
    input  logic [NUM_REQ-1:0][REG_WIDTH-1:0] req_a,
    input  logic [NUM_REQ-1:0][REG_WIDTH-1:0] req_b,
    input  logic [NUM_REQ-1:0][3:0]           req_op,
    output logic [NUM_REQ-1:0]                rsp_valid,
    input  logic [NUM_REQ-1:0]                rsp_ready,
    output logic [REG_WIDTH-1:0]              rsp_data
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

    alu_arb_state_t       state, state_next;
    logic [PTR_W-1:0]     owner;
    logic [PTR_W-1:0]     last_ptr;
    logic [PTR_W-1:0]     gnt;
    logic                 gnt_found;
    logic                 accept;
    logic [REG_WIDTH-1:0] alu_res;
    logic [REG_WIDTH-1:0] data_p1;

`ifdef ALU_ARB_FIXED_PRIO_EN
    always_comb begin
        gnt       = '0;
        gnt_found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            logic [PTR_W-1:0] cand;
            cand = PTR_W'(k);
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt       = cand;
            end
        end
    end
`else
    // Search starts one past the last accepted requester and wraps.
    always_comb begin
        gnt       = '0;
        gnt_found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            int               idx;
            logic [PTR_W-1:0] cand;
            idx = int'(last_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            cand = PTR_W'(idx);
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt       = cand;
            end
        end
    end
`endif

    // A new op can enter while the held result drains in the same cycle.
    assign accept    = gnt_found && ((state == IDLE) || rsp_ready[owner]);
    assign req_ready = accept ? (ONE << gnt) : '0;

    alu_arbiter_alu u_alu (
        .op     (req_op[gnt]),
        .a      (req_a[gnt]),
        .b      (req_b[gnt]),
        .result (alu_res)
    );

    always_comb begin
        state_next = state;
        if (accept) begin
            state_next = HOLD;
        end else if ((state == HOLD) && rsp_ready[owner]) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---- stage p1: registered result and ownership ----
    always_ff @(posedge clk) begin
        if (reset) begin
            owner    <= '0;
            last_ptr <= PTR_W'(NUM_REQ - 1);
            data_p1  <= '0;
        end else if (accept) begin
            owner    <= gnt;
            last_ptr <= gnt;
            data_p1  <= alu_res;
        end
    end

    assign rsp_valid = (state == HOLD) ? (ONE << owner) : '0;
    assign rsp_data  = data_p1;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with two requesters.
module tb_alu_arbiter;
    import riscv_pkg::*;

    logic                        clk;
    logic                        reset;
    logic [1:0]                  req_valid;
    logic [1:0]                  req_ready;
    logic [1:0][REG_WIDTH-1:0]   req_a;
    logic [1:0][REG_WIDTH-1:0]   req_b;
    logic [1:0][3:0]             req_op;
    logic [1:0]                  rsp_valid;
    logic [1:0]                  rsp_ready;
    logic [REG_WIDTH-1:0]        rsp_data;

    int total;
    int bad;

    alu_arbiter #(.NUM_REQ(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[9];
    logic [1:0] g_exp;

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        req_op = '0;
        rsp_ready = '0;

        vecs[0] = '{ALU_AND,  32'h0000F0F0, 32'h0000FF00, 32'h0000F000};
        vecs[1] = '{ALU_OR,   32'h0000000F, 32'h000000F0, 32'h000000FF};
        vecs[2] = '{ALU_XOR,  32'h000000FF, 32'h0000000F, 32'h000000F0};
        vecs[3] = '{ALU_SLL,  32'h00000001, 32'h00000021, 32'h00000002};
        vecs[4] = '{ALU_SRL,  32'h80000000, 32'h00000004, 32'h08000000};
        vecs[5] = '{ALU_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001};
        vecs[6] = '{ALU_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000};
        vecs[7] = '{ALU_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000};
        vecs[8] = '{4'b0111,  32'h00000009, 32'h00000009, 32'h00000000};

        tick();
        tick();
        check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        check("reset_rsp_data", rsp_data, 32'h0);
        reset = 1'b0;

        // Single ADD from requester 0
        req_valid = 2'b01;
        req_op[0] = ALU_ADD; req_a[0] = 32'd5; req_b[0] = 32'd7;
        rsp_ready = 2'b11;
        #1;
        check("add_req_ready", 32'(req_ready), 32'h1);
        tick();
        check("add_rsp_valid", 32'(rsp_valid), 32'h1);
        check("add_rsp_data", rsp_data, 32'd12);
        req_valid = 2'b00;
        tick();
        check("add_drain_idle", 32'(rsp_valid), 32'h0);

        // Fresh reset so requester 0 wins first, then both contend
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req_valid = 2'b11;
        req_op[0] = ALU_OR; req_a[0] = 32'd1; req_b[0] = 32'd0;
        req_op[1] = ALU_OR; req_a[1] = 32'd2; req_b[1] = 32'd0;
        rsp_ready = 2'b11;
        for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            g_exp = 2'b01;
`else
            g_exp = (k % 2 == 0) ? 2'b01 : 2'b10;
`endif
            #1;
            check($sformatf("rr_req_ready_%0d", k), 32'(req_ready), 32'(g_exp));
            tick();
            check($sformatf("rr_rsp_valid_%0d", k), 32'(rsp_valid), 32'(g_exp));
            check($sformatf("rr_rsp_data_%0d", k), rsp_data, (g_exp == 2'b01) ? 32'd1 : 32'd2);
        end
        req_valid = 2'b00;
        tick();
        check("rr_drain_idle", 32'(rsp_valid), 32'h0);

        // Requester 1 SRA held while its rsp_ready is low
        req_valid = 2'b10;
        req_op[1] = ALU_SRA; req_a[1] = 32'h80000000; req_b[1] = 32'h00000024;
        rsp_ready = 2'b00;
        #1;
        check("sra_req_ready", 32'(req_ready), 32'h2);
        tick();
        check("sra_rsp_valid", 32'(rsp_valid), 32'h2);
        check("sra_rsp_data", rsp_data, 32'hF8000000);
        req_valid = 2'b01;
        req_op[0] = ALU_OR; req_a[0] = 32'd3; req_b[0] = 32'd0;
        rsp_ready = 2'b01;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("hold_req_ready_%0d", k), 32'(req_ready), 32'h0);
            tick();
            check($sformatf("hold_rsp_valid_%0d", k), 32'(rsp_valid), 32'h2);
            check($sformatf("hold_rsp_data_%0d", k), rsp_data, 32'hF8000000);
        end
        rsp_ready = 2'b10;
        #1;
        check("refill_req_ready", 32'(req_ready), 32'h1);
        tick();
        check("refill_rsp_valid", 32'(rsp_valid), 32'h1);
        check("refill_rsp_data", rsp_data, 32'd3);
        req_valid = 2'b00;
        rsp_ready = 2'b01;
        tick();
        check("refill_drain_idle", 32'(rsp_valid), 32'h0);

        // Back-to-back SUB then SLTU from requester 0
        req_valid = 2'b01;
        req_op[0] = ALU_SUB; req_a[0] = 32'd3; req_b[0] = 32'd5;
        #1;
        check("sub_req_ready", 32'(req_ready), 32'h1);
        tick();
        check("sub_rsp_data", rsp_data, 32'hFFFFFFFE);
        req_op[0] = ALU_SLTU; req_a[0] = 32'd3; req_b[0] = 32'hFFFFFFFF;
        #1;
        check("sltu_req_ready", 32'(req_ready), 32'h1);
        tick();
        check("sltu_rsp_valid", 32'(rsp_valid), 32'h1);
        check("sltu_rsp_data", rsp_data, 32'd1);

        // Opcode table, one op per cycle
        for (int k = 0; k < 9; k++) begin
            req_op[0] = vecs[k].op; req_a[0] = vecs[k].a; req_b[0] = vecs[k].b;
            tick();
            check($sformatf("op_rsp_valid_%0d", k), 32'(rsp_valid), 32'h1);
            check($sformatf("op_rsp_data_%0d", k), rsp_data, vecs[k].exp);
        end
        req_valid = 2'b00;
        tick();
        check("op_drain_idle", 32'(rsp_valid), 32'h0);

        // Reset while holding a result for requester 0
        req_valid = 2'b01;
        req_op[0] = ALU_ADD; req_a[0] = 32'd1; req_b[0] = 32'd1;
        rsp_ready = 2'b00;
        tick();
        check("pre_reset_rsp_valid", 32'(rsp_valid), 32'h1);
        check("pre_reset_rsp_data", rsp_data, 32'd2);
        req_valid = 2'b00;
        reset = 1'b1;
        tick();
        check("post_reset_rsp_valid", 32'(rsp_valid), 32'h0);
        check("post_reset_rsp_data", rsp_data, 32'h0);
        reset = 1'b0;
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        #1;
        check("post_reset_grant", 32'(req_ready), 32'h1);
        tick();
        check("post_reset_rsp", 32'(rsp_valid), 32'h1);
        req_valid = 2'b00;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
